// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO behind the UART receiver: buffers {frame_err, data} per frame,
// first-word fall-through to the host, with sticky overrun and almost-full level.
module uart_rx_fifo #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned AF_LEVEL = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_din,
  input  logic              rx_frame_err,
  input  logic              rx_done,
  input  logic              rd_en,
  input  logic              clr_overrun,
  output logic [DATA_W-1:0] dout,
  output logic              dout_frame_err,
  output logic              valid,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overrun
);

  localparam int unsigned Depth = 32'd1 << ADDR_W;
  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(Depth);
  localparam logic [ADDR_W:0] AfCnt    = (ADDR_W + 1)'(AF_LEVEL);

  logic [DATA_W:0]   mem_q [Depth];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overrun_q, overrun_d;
  logic              rd_accept, wr_accept, drop;

  // Flags decode from the registered count only, so they move only on clk or reset.
  assign valid       = (count_q != '0);
  assign full        = (count_q == DepthCnt);
  assign almost_full = (count_q >= AfCnt);
  assign count       = count_q;
  assign overrun     = overrun_q;

  assign dout           = mem_q[rd_ptr_q][DATA_W-1:0];
  assign dout_frame_err = mem_q[rd_ptr_q][DATA_W];

  // A pop from a full FIFO frees the slot for a same-cycle write.
  assign rd_accept = rd_en & valid;
  assign wr_accept = rx_done & (~full | rd_accept);
  assign drop      = rx_done & full & ~rd_accept;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_accept) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Set wins over a simultaneous clear.
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      if (wr_accept) begin
        mem_q[wr_ptr_q] <= {rx_frame_err, rx_din};
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: ordering, flags, overrun, pointer wrap, async reset.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_din;
  logic       rx_frame_err;
  logic       rx_done;
  logic       rd_en;
  logic       clr_overrun;
  logic [7:0] dout;
  logic       dout_frame_err;
  logic       valid;
  logic       full;
  logic       almost_full;
  logic [4:0] count;
  logic       overrun;

  int total = 0;
  int bad   = 0;
  logic [7:0] model_q[$];
  logic [7:0] exp_b;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .ADDR_W  (4),
    .DATA_W  (8),
    .AF_LEVEL(12)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_din        (rx_din),
    .rx_frame_err  (rx_frame_err),
    .rx_done       (rx_done),
    .rd_en         (rd_en),
    .clr_overrun   (clr_overrun),
    .dout          (dout),
    .dout_frame_err(dout_frame_err),
    .valid         (valid),
    .full          (full),
    .almost_full   (almost_full),
    .count         (count),
    .overrun       (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Apply current inputs across one rising edge, then return inputs to idle.
  task automatic step();
    @(posedge clk);
    #1;
    rx_done     = 1'b0;
    rd_en       = 1'b0;
    clr_overrun = 1'b0;
    rx_frame_err = 1'b0;
  endtask

  task automatic push(input logic [7:0] b, input logic fe);
    rx_din = b;
    rx_frame_err = fe;
    rx_done = 1'b1;
    step();
  endtask

  task automatic pop();
    rd_en = 1'b1;
    step();
  endtask

  initial begin
    rst = 1'b0;
    rx_din = '0;
    rx_frame_err = 1'b0;
    rx_done = 1'b0;
    rd_en = 1'b0;
    clr_overrun = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_ovr", 32'(overrun), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_dfe", 32'(dout_frame_err), 0);
    rst = 1'b1;
    step();

    // Single write / read
    push(8'hA5, 1'b0);
    chk("one_valid", 32'(valid), 1);
    chk("one_dout", 32'(dout), 32'hA5);
    chk("one_count", 32'(count), 1);
    pop();
    chk("one_pop_valid", 32'(valid), 0);
    chk("one_pop_count", 32'(count), 0);

    // Fill 0..15, checking level flags
    for (int i = 0; i < 16; i++) begin
      push(8'(i), 1'b0);
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_af", 32'(almost_full), 32'((i + 1) >= 12));
      chk("fill_full", 32'(full), 32'((i + 1) == 16));
    end
    for (int i = 0; i < 16; i++) begin
      chk("drain_dout", 32'(dout), 32'(i));
      pop();
    end
    chk("drain_valid", 32'(valid), 0);
    chk("drain_count", 32'(count), 0);

    // Overrun
    for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
    push(8'h55, 1'b0);
    chk("ovr_flag", 32'(overrun), 1);
    chk("ovr_count", 32'(count), 16);
    chk("ovr_head", 32'(dout), 0);
    clr_overrun = 1'b1;
    step();
    chk("ovr_clr", 32'(overrun), 0);

    // Simultaneous read+write when full
    rx_din = 8'h77;
    rx_done = 1'b1;
    rd_en = 1'b1;
    step();
    chk("rw_full_count", 32'(count), 16);
    chk("rw_full_ovr", 32'(overrun), 0);
    for (int i = 1; i < 16; i++) begin
      chk("rw_full_order", 32'(dout), 32'(i));
      pop();
    end
    chk("rw_full_last", 32'(dout), 32'h77);
    pop();
    chk("rw_full_empty", 32'(valid), 0);

    // Simultaneous read+write when empty: only the write lands
    rx_din = 8'h11;
    rx_done = 1'b1;
    rd_en = 1'b1;
    step();
    chk("rw_empty_count", 32'(count), 1);
    chk("rw_empty_dout", 32'(dout), 32'h11);
    pop();

    // Framing error propagation
    push(8'h3C, 1'b1);
    chk("fe_flag", 32'(dout_frame_err), 1);
    chk("fe_dout", 32'(dout), 32'h3C);
    pop();
    chk("fe_pop_count", 32'(count), 0);

    // Pointer wrap with 40 write/read pairs, three entries in flight
    for (int i = 0; i < 3; i++) begin
      push(8'(8'h80 + i), 1'b0);
      model_q.push_back(8'(8'h80 + i));
    end
    for (int i = 0; i < 40; i++) begin
      exp_b = model_q.pop_front();
      chk("wrap_dout", 32'(dout), 32'(exp_b));
      rx_din = 8'(8'hC0 + i);
      rx_done = 1'b1;
      rd_en = 1'b1;
      model_q.push_back(8'(8'hC0 + i));
      step();
      if (count > 5'd16) chk("wrap_bound", 32'(count), 16);
      if (i % 10 == 9) chk("wrap_count", 32'(count), 3);
    end
    while (model_q.size() > 0) begin
      exp_b = model_q.pop_front();
      chk("wrap_tail", 32'(dout), 32'(exp_b));
      pop();
    end
    chk("wrap_empty", 32'(valid), 0);

    // Async reset mid-cycle with 5 entries and overrun set
    for (int i = 0; i < 16; i++) push(8'(i + 1), 1'b0);
    push(8'hEE, 1'b0);
    for (int i = 0; i < 11; i++) pop();
    chk("pre_rst_count", 32'(count), 5);
    chk("pre_rst_ovr", 32'(overrun), 1);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_valid", 32'(valid), 0);
    chk("arst_ovr", 32'(overrun), 0);
    chk("arst_dout", 32'(dout), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    pop();
    chk("empty_rd_count", 32'(count), 0);
    chk("empty_rd_valid", 32'(valid), 0);
    chk("empty_rd_ovr", 32'(overrun), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the UART receiver datapath/control.
- Captures each completed 8-bit frame plus its framing-error status into a first-word-fall-through FIFO.
- Presents entries to the host-side consumer through a valid/read-enable interface.
- Tracks overrun (frame arrived while full) and an almost-full level for flow control.

Parameters:
- ADDR_W, 4, log2 of FIFO depth (depth = 2^ADDR_W = 16 entries)
- DATA_W, 8, data bits per frame
- AF_LEVEL, 12, count at or above which almost_full asserts (1..2^ADDR_W)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- rx_din  input  DATA_W  received byte from the receiver shift register
- rx_frame_err  input  1  stop bit sampled as 0 for this frame
- rx_done  input  1  one-cycle pulse: rx_din/rx_frame_err valid, write request
- rd_en  input  1  consumer pops head entry
- clr_overrun  input  1  synchronous clear of the sticky overrun flag
- dout  output  DATA_W  head-entry data (first-word fall-through)
- dout_frame_err  output  1  head-entry framing-error flag
- valid  output  1  FIFO non-empty; dout/dout_frame_err meaningful
- full  output  1  count == 2^ADDR_W
- almost_full  output  1  count >= AF_LEVEL
- count  output  ADDR_W+1  number of stored entries, 0..2^ADDR_W
- overrun  output  1  sticky: a frame was dropped

Behaviour:
- Reset (rst=0, asynchronous):
  - wr_ptr, rd_ptr and count go to 0; all storage entries go to 0.
  - valid=0, full=0, almost_full=0, overrun=0, dout=0, dout_frame_err=0.
  - A reset mid-operation discards all contents immediately.
- Storage: 2^ADDR_W entries of DATA_W+1 bits {frame_err, data}. Pointers are ADDR_W bits and wrap naturally from 2^ADDR_W-1 to 0.
- Write: on a clk edge with rx_done=1 and (full=0 or an accepted read in the same cycle):
  - The entry is stored at wr_ptr.
  - wr_ptr increments.
- Read: on a clk edge with rd_en=1 and valid=1:
  - rd_ptr increments.
  - rd_en while valid=0 is ignored: no pointer or count change, no flag set.
- Count update per edge:
  - write only: +1
  - read only: -1
  - both: unchanged
  - neither: unchanged
- Simultaneous read+write:
  - When full: both accepted; count stays 2^ADDR_W; no overrun.
  - When empty: write accepted, read ignored; count becomes 1.
- Overrun: rx_done=1 while full=1 and no accepted read that cycle:
  - The frame is dropped and contents are unchanged.
  - overrun is set to 1 on that edge.
  - clr_overrun=1 clears it on the next edge. If clr_overrun and a new overrun occur in the same cycle, overrun is 1 (set wins).
- Output timing:
  - dout/dout_frame_err combinationally reflect storage[rd_ptr].
  - The first write into an empty FIFO makes valid=1 and dout valid in the cycle after the write edge (1-cycle latency).
  - After a pop, the next entry appears the cycle after the read edge.
- Flags full, almost_full and valid are decoded from the registered count. They are glitch-free with respect to clk and change only after a clk edge or reset.
- rx_done is a single-cycle pulse by contract. Each high cycle is treated as a separate write request.

Test Plan:
- Reset, then write 0xA5 (frame_err=0) → next cycle valid=1, dout=0xA5, count=1; rd_en one cycle → valid=0, count=0.
- Write 16 bytes 0x00..0x0F → almost_full=1 once count=12, full=1 at count=16. Pop all → order 0x00..0x0F, then valid=0.
- Fill to 16, then pulse rx_done with 0x55 and rd_en=0 → overrun=1, count=16, head still 0x00. Pulse clr_overrun → overrun=0.
- Full FIFO, rx_done and rd_en in the same cycle with 0x77 → count stays 16, no overrun; 0x77 is read as the 16th entry after the other 15.
- Write 0x3C with rx_frame_err=1 → dout_frame_err=1 with dout=0x3C. Drive 40 write/read pairs to force pointer wrap → data order preserved, count never exceeds 16.
- Load 5 entries, assert rst=0 mid-cycle (asynchronous) → count=0, valid=0, overrun=0 immediately. rd_en while empty → no change.
